// File: rtl/mips_bus_pkg.sv
// Shared bus definitions for the multicycle MIPS core and its memory arbiter.
package mips_bus_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic [31:0]               RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [DATA_W_DEF/8-1:0]   BE_ALL       = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    ABORT = 2'd3
  } arb_state_e;

  // One-hot owner of the slave port for a given arbiter state.
  function automatic logic [1:0] grant_of(arb_state_e s);
    return {s == OWN1, s == OWN0};
  endfunction

endpackage

// File: rtl/mips_bus_watchdog.sv
// Stall counter for the bus arbiter: counts enabled cycles, clears on request,
// and flags expiry on the LIMIT-th enabled cycle. LIMIT = 0 disables it.
module mips_bus_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  generate
    if (LIMIT == 0) begin : g_off
      assign expire_o = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(LIMIT + 1);

      logic [CW-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (clear_i)       cnt_d = '0;
        else if (enable_i) cnt_d = cnt_q + CW'(1);
      end

      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
      end

      assign expire_o = enable_i && (cnt_q == CW'(LIMIT - 1));
    end
  endgenerate

endmodule

// File: rtl/mips_bus_arbiter.sv
// Two-master Avalon-MM arbiter for the multicycle MIPS core with a stall watchdog.
// Build option MIPS_ARB_FIXED_PRIO_EN: m0 always wins ties instead of round-robin.
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  output logic [1:0]          grant,
  output logic                timeout
);

  arb_state_e state_q, state_d;
  logic [1:0] grant_q;
  logic       timeout_q;
  logic       abort_m1_q, abort_m1_d;
  logic       m0_req, m1_req, pick_m1, owning, done, expire;
  logic       abort_m0, abort_m1;

  assign m0_req = m0_read | m0_write;
  assign m1_req = m1_read | m1_write;

`ifdef MIPS_ARB_FIXED_PRIO_EN
  assign pick_m1 = m1_req & ~m0_req;
`else
  logic rr_ptr_q, rr_ptr_d;
  assign pick_m1 = m1_req & (~m0_req | rr_ptr_q);
`endif

  // Only the owner reaches the slave; read+write together is issued as a write.
  always_comb begin
    s_address    = '0;
    s_read       = 1'b0;
    s_write      = 1'b0;
    s_writedata  = '0;
    s_byteenable = '0;
    unique case (state_q)
      OWN0: begin
        s_address    = m0_address;
        s_read       = m0_read & ~m0_write;
        s_write      = m0_write;
        s_writedata  = m0_writedata;
        s_byteenable = m0_byteenable;
      end
      OWN1: begin
        s_address    = m1_address;
        s_read       = m1_read & ~m1_write;
        s_write      = m1_write;
        s_writedata  = m1_writedata;
        s_byteenable = m1_byteenable;
      end
      default: ;
    endcase
  end

  assign owning = (state_q == OWN0) || (state_q == OWN1);
  assign done   = (s_read | s_write) & ~s_waitrequest;

  mips_bus_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear_i (state_d != state_q),
    .enable_i(owning & s_waitrequest),
    .expire_o(expire)
  );

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d    = state_q;
    abort_m1_d = abort_m1_q;
`ifndef MIPS_ARB_FIXED_PRIO_EN
    rr_ptr_d   = rr_ptr_q;
`endif
    unique case (state_q)
      IDLE: if (m0_req || m1_req) state_d = pick_m1 ? OWN1 : OWN0;
      OWN0: begin
        if (!m0_req) state_d = IDLE;
        else if (done) begin
          state_d = m1_req ? OWN1 : IDLE;
`ifndef MIPS_ARB_FIXED_PRIO_EN
          rr_ptr_d = 1'b1;
`endif
        end else if (expire) begin
          state_d    = ABORT;
          abort_m1_d = 1'b0;
        end
      end
      OWN1: begin
        if (!m1_req) state_d = IDLE;
        else if (done) begin
          state_d = m0_req ? OWN0 : IDLE;
`ifndef MIPS_ARB_FIXED_PRIO_EN
          rr_ptr_d = 1'b0;
`endif
        end else if (expire) begin
          state_d    = ABORT;
          abort_m1_d = 1'b1;
        end
      end
      ABORT: begin
        state_d = IDLE;
`ifndef MIPS_ARB_FIXED_PRIO_EN
        rr_ptr_d = ~abort_m1_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= 2'b00;
      timeout_q  <= 1'b0;
      abort_m1_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_of(state_d);
      timeout_q  <= (state_d == ABORT);
      abort_m1_q <= abort_m1_d;
    end
  end

`ifndef MIPS_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk) begin
    if (reset) rr_ptr_q <= 1'b0;
    else       rr_ptr_q <= rr_ptr_d;
  end
`endif

  // An aborted owner is released with zeroed read data; everyone else waits.
  assign abort_m0 = (state_q == ABORT) & ~abort_m1_q;
  assign abort_m1 = (state_q == ABORT) &  abort_m1_q;

  assign m0_waitrequest = (state_q == OWN0) ? s_waitrequest : ~abort_m0;
  assign m1_waitrequest = (state_q == OWN1) ? s_waitrequest : ~abort_m1;
  assign m0_readdata    = abort_m0 ? '0 : s_readdata;
  assign m1_readdata    = abort_m1 ? '0 : s_readdata;

  assign grant   = grant_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed self-checking bench for mips_bus_arbiter (watchdog limit 4).
// Expectations follow MIPS_ARB_FIXED_PRIO_EN when the bench is built with it.
module tb_mips_bus_arbiter;
  import mips_bus_pkg::*;

`ifdef MIPS_ARB_FIXED_PRIO_EN
  localparam logic [1:0] RR_FIRST = 2'b01;
`else
  localparam logic [1:0] RR_FIRST = 2'b10;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_address, m0_writedata, m0_readdata;
  logic        m0_read, m0_write, m0_waitrequest;
  logic [3:0]  m0_byteenable;
  logic [31:0] m1_address, m1_writedata, m1_readdata;
  logic        m1_read, m1_write, m1_waitrequest;
  logic [3:0]  m1_byteenable;
  logic [31:0] s_address, s_writedata, s_readdata;
  logic        s_read, s_write, s_waitrequest;
  logic [3:0]  s_byteenable;
  logic [1:0]  grant;
  logic        timeout;
  logic [1:0]  rr_second;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  mips_bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .grant(grant), .timeout(timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick(); #1;
    n_total++; if (grant !== 2'b00) $display("FAIL rst_grant: got %b want 00", grant); else n_pass++;
    n_total++; if (timeout !== 1'b0) $display("FAIL rst_timeout: got %b want 0", timeout); else n_pass++;
    n_total++; if ({s_read, s_write} !== 2'b00) $display("FAIL rst_s_rw: got %b want 00", {s_read, s_write}); else n_pass++;
    n_total++; if ({s_address, s_writedata, s_byteenable} !== 68'd0)
      $display("FAIL rst_s_bus: got %h want 0", {s_address, s_writedata, s_byteenable}); else n_pass++;
    n_total++; if ({m0_waitrequest, m1_waitrequest} !== 2'b11)
      $display("FAIL rst_wait: got %b want 11", {m0_waitrequest, m1_waitrequest}); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    tick();
    m0_address = RESET_VECTOR; m0_byteenable = BE_ALL; m0_read = 1'b1;
    s_waitrequest = 1'b0; s_readdata = 32'hCAFE_F00D; #1;
    n_total++; if ({grant, m0_waitrequest, s_read} !== 4'b0010)
      $display("FAIL rd_c1: got %b want 0010", {grant, m0_waitrequest, s_read}); else n_pass++;
    tick(); #1;
    n_total++; if (grant !== 2'b01) $display("FAIL rd_c2_grant: got %b want 01", grant); else n_pass++;
    n_total++; if (s_address !== 32'hBFC0_0000) $display("FAIL rd_c2_addr: got %h want bfc00000", s_address); else n_pass++;
    n_total++; if ({s_read, s_write, m0_waitrequest, s_byteenable} !== 7'b100_1111)
      $display("FAIL rd_c2_ctl: got %b want 1001111", {s_read, s_write, m0_waitrequest, s_byteenable}); else n_pass++;
    n_total++; if (m0_readdata !== 32'hCAFE_F00D) $display("FAIL rd_c2_data: got %h want cafef00d", m0_readdata); else n_pass++;
    tick(); m0_read = 1'b0; #1;
    n_total++; if ({grant, s_read} !== 3'b000) $display("FAIL rd_c3_idle: got %b want 000", {grant, s_read}); else n_pass++;
  endtask

  task automatic test_round_robin();
    reset = 1'b1; tick(); reset = 1'b0;
    m0_address = 32'h100; m1_address = 32'h200; m0_read = 1'b1; m1_read = 1'b1; s_waitrequest = 1'b0; #1;
    n_total++; if ({grant, m0_waitrequest, m1_waitrequest} !== 4'b0011)
      $display("FAIL rr_arb: got %b want 0011", {grant, m0_waitrequest, m1_waitrequest}); else n_pass++;
    tick(); #1;
    n_total++; if ({grant, s_address, m0_waitrequest, m1_waitrequest} !== {2'b01, 32'h100, 2'b01})
      $display("FAIL rr_first_m0: got %h want %h", {grant, s_address, m0_waitrequest, m1_waitrequest}, {2'b01, 32'h100, 2'b01}); else n_pass++;
    tick(); m0_read = 1'b0; #1;
    n_total++; if ({grant, s_address, m1_waitrequest} !== {2'b10, 32'h200, 1'b0})
      $display("FAIL rr_b2b_m1: got %h want %h", {grant, s_address, m1_waitrequest}, {2'b10, 32'h200, 1'b0}); else n_pass++;
    tick(); m1_read = 1'b0; m0_address = 32'h104; m0_read = 1'b1; #1;
    n_total++; if (grant !== 2'b00) $display("FAIL rr_idle_after_pair: got %b want 00", grant); else n_pass++;
    tick(); #1;
    n_total++; if (grant !== 2'b01) $display("FAIL rr_m0_alone: got %b want 01", grant); else n_pass++;
    tick(); m1_read = 1'b1; #1;
    n_total++; if (grant !== 2'b00) $display("FAIL rr_idle2: got %b want 00", grant); else n_pass++;
    tick(); #1;
    n_total++; if (grant !== RR_FIRST) $display("FAIL rr_repeat_first: got %b want %b", grant, RR_FIRST); else n_pass++;
    tick();
    if (RR_FIRST[1]) m1_read = 1'b0; else m0_read = 1'b0;
    #1;
    n_total++; if (grant !== rr_second) $display("FAIL rr_repeat_b2b: got %b want %b", grant, rr_second); else n_pass++;
    tick(); m0_read = 1'b0; m1_read = 1'b0; #1;
    n_total++; if (grant !== 2'b00) $display("FAIL rr_end_idle: got %b want 00", grant); else n_pass++;
  endtask

`ifdef MIPS_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    for (int i = 0; i < 3; i++) begin
      tick(); m0_read = 1'b1; m1_read = 1'b1; s_waitrequest = 1'b0;
      tick(); #1;
      n_total++; if (grant !== 2'b01) $display("FAIL fp_win_%0d: got %b want 01", i, grant); else n_pass++;
      tick(); m0_read = 1'b0;
      tick(); m1_read = 1'b0;
    end
  endtask
`endif

  task automatic test_write_stall();
    tick();
    m1_address = 32'h300; m1_writedata = 32'h1234_5678; m1_byteenable = 4'b0011;
    m1_write = 1'b1; s_waitrequest = 1'b1; #1;
    n_total++; if (grant !== 2'b00) $display("FAIL wr_arb: got %b want 00", grant); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 0) begin m0_address = 32'h400; m0_read = 1'b1; end
      #1;
      n_total++; if ({grant, m1_waitrequest, m0_waitrequest, s_write, s_read} !== 6'b10_1110)
        $display("FAIL wr_stall_%0d: got %b want 101110", i, {grant, m1_waitrequest, m0_waitrequest, s_write, s_read}); else n_pass++;
      n_total++; if ({s_writedata, s_byteenable, s_address} !== {32'h1234_5678, 4'b0011, 32'h300})
        $display("FAIL wr_data_%0d: got %h want %h", i, {s_writedata, s_byteenable, s_address}, {32'h1234_5678, 4'b0011, 32'h300}); else n_pass++;
    end
    tick(); s_waitrequest = 1'b0; #1;
    n_total++; if ({grant, m1_waitrequest, s_write} !== 4'b1001)
      $display("FAIL wr_done: got %b want 1001", {grant, m1_waitrequest, s_write}); else n_pass++;
    tick(); m1_write = 1'b0; #1;
    n_total++; if ({grant, s_address, s_read, m0_waitrequest} !== {2'b01, 32'h400, 2'b10})
      $display("FAIL wr_b2b_m0: got %h want %h", {grant, s_address, s_read, m0_waitrequest}, {2'b01, 32'h400, 2'b10}); else n_pass++;
    tick(); m0_read = 1'b0; #1;
    n_total++; if (grant !== 2'b00) $display("FAIL wr_end_idle: got %b want 00", grant); else n_pass++;
  endtask

  task automatic test_timeout();
    tick(); m1_address = 32'h600; m1_read = 1'b1; s_waitrequest = 1'b0;
    tick(); #1;
    n_total++; if (grant !== 2'b10) $display("FAIL to_pre_m1: got %b want 10", grant); else n_pass++;
    tick();
    m1_read = 1'b0; m0_address = 32'h500; m0_read = 1'b1;
    s_waitrequest = 1'b1; s_readdata = 32'hDEAD_BEEF; #1;
    n_total++; if (grant !== 2'b00) $display("FAIL to_arb: got %b want 00", grant); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      n_total++; if ({grant, m0_waitrequest, timeout} !== 4'b0110)
        $display("FAIL to_stall_%0d: got %b want 0110", i, {grant, m0_waitrequest, timeout}); else n_pass++;
    end
    tick(); #1;
    n_total++; if ({timeout, m0_waitrequest, m0_readdata} !== 34'h2_0000_0000)
      $display("FAIL to_abort: got %h want 200000000", {timeout, m0_waitrequest, m0_readdata}); else n_pass++;
    n_total++; if ({s_read, s_write, m1_waitrequest, m1_readdata} !== {3'b001, 32'hDEAD_BEEF})
      $display("FAIL to_abort_bus: got %h want %h", {s_read, s_write, m1_waitrequest, m1_readdata}, {3'b001, 32'hDEAD_BEEF}); else n_pass++;
    tick(); m1_read = 1'b1; #1;
    n_total++; if ({grant, timeout} !== 3'b000) $display("FAIL to_idle: got %b want 000", {grant, timeout}); else n_pass++;
    tick(); #1;
    n_total++; if (grant !== RR_FIRST) $display("FAIL to_rr_next: got %b want %b", grant, RR_FIRST); else n_pass++;
  endtask

  task automatic test_reset_midtx();
    reset = 1'b1;
    tick(); #1;
    n_total++; if ({grant, s_read, s_write, timeout} !== 5'b00000)
      $display("FAIL midrst_out: got %b want 00000", {grant, s_read, s_write, timeout}); else n_pass++;
    n_total++; if ({m0_waitrequest, m1_waitrequest} !== 2'b11)
      $display("FAIL midrst_wait: got %b want 11", {m0_waitrequest, m1_waitrequest}); else n_pass++;
    reset = 1'b0; m0_read = 1'b0; m1_read = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    rr_second = {RR_FIRST[0], RR_FIRST[1]};
    m0_address = '0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = '0; m0_byteenable = '0;
    m1_address = '0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0; m1_byteenable = '0;
    s_waitrequest = 1'b0; s_readdata = '0;
    test_reset();
    test_single_read();
    test_round_robin();
`ifdef MIPS_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    test_write_stall();
    test_timeout();
    test_reset_midtx();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL tb_time_limit: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
